// File: rtl/nf5_mem_pkg.sv
// ============================================================================
// Module   : nf5_mem_pkg
// Purpose  : Shared types and default widths for the NF5 memory-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nf5_mem_pkg;

  localparam int c_def_addr_w  = 32;
  localparam int c_def_data_w  = 32;
  localparam int c_def_mem_lat = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    IF = 2'd0,
    LS = 2'd1,
    LD = 2'd2
  } arb_owner_t;

  // Latency counter must be able to hold MEM_LAT itself.
  function automatic int lat_cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Fetch, load/store, RAM and (with MEM_ARB_LOADER_EN) loader signals.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if
  import nf5_mem_pkg::*;
#(
  parameter int ADDR_W = c_def_addr_w,
  parameter int DATA_W = c_def_data_w
) ();

  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  ls_req;
  logic                  ls_we;
  logic [DATA_W/8-1:0]   ls_be;
  logic [ADDR_W-1:0]     ls_addr;
  logic [DATA_W-1:0]     ls_wdata;
  logic                  ls_gnt;
  logic                  ls_rvalid;
  logic [DATA_W-1:0]     ls_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  arb_busy;

`ifdef MEM_ARB_LOADER_EN
  logic                  ld_req;
  logic [ADDR_W-1:0]     ld_addr;
  logic [DATA_W-1:0]     ld_wdata;
  logic                  ld_gnt;
`endif

  modport slave (
`ifdef MEM_ARB_LOADER_EN
    input  ld_req, ld_addr, ld_wdata,
    output ld_gnt,
`endif
    input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata, arb_busy
  );

  modport master (
`ifdef MEM_ARB_LOADER_EN
    output ld_req, ld_addr, ld_wdata,
    input  ld_gnt,
`endif
    output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, arb_busy
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick2.sv
// ============================================================================
// Module   : rr_pick2
// Purpose  : Two-input round-robin picker; ties go to the input not granted last.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  // High when b (LS) held the last grant; resets so that a (IF) wins the first tie.
  logic r_last_b;

  assign gnt_a = req_a & (~req_b | r_last_b);
  assign gnt_b = req_b & (~req_a | ~r_last_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b <= 1'b1;
    end else if (gnt_a | gnt_b) begin
      r_last_b <= gnt_b;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin IF/LS share of a fixed-latency single-port RAM.
//            Optional loader port compiled in with MEM_ARB_LOADER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import nf5_mem_pkg::*;
#(
  parameter int ADDR_W  = c_def_addr_w,
  parameter int DATA_W  = c_def_data_w,
  parameter int MEM_LAT = c_def_mem_lat
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus
);

  localparam int                BE_W  = DATA_W / 8;
  localparam int                CNT_W = lat_cnt_w(MEM_LAT);
  localparam logic [CNT_W-1:0]  c_lat = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0]  c_one = CNT_W'(1);

  arb_state_t            r_state;
  arb_owner_t            r_owner;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_store;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [BE_W-1:0]       r_mem_be;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic                  r_if_rvalid;
  logic                  r_ls_rvalid;
  logic [DATA_W-1:0]     r_if_rdata;
  logic [DATA_W-1:0]     r_ls_rdata;

  logic                  w_can_grant;
  logic                  w_rr_en;
  logic                  w_if_gnt;
  logic                  w_ls_gnt;
  logic                  w_ld_gnt;
  logic                  w_accept;

  // Gating with rst_n keeps every output low while reset is held.
  assign w_can_grant = rst_n & ((r_state == IDLE) | (r_state == RESP));

`ifdef MEM_ARB_LOADER_EN
  assign w_ld_gnt = w_can_grant & bus.ld_req;
  assign w_rr_en  = w_can_grant & ~bus.ld_req;
  assign bus.ld_gnt = w_ld_gnt;
`else
  assign w_ld_gnt = 1'b0;
  assign w_rr_en  = w_can_grant;
`endif

  rr_pick2 u_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .req_a (w_rr_en & bus.if_req),
    .req_b (w_rr_en & bus.ls_req),
    .gnt_a (w_if_gnt),
    .gnt_b (w_ls_gnt)
  );

  assign w_accept = w_if_gnt | w_ls_gnt | w_ld_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= IF;
      r_cnt       <= '0;
      r_store     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      case (r_state)
        IDLE, RESP: begin
          if (w_accept) begin
            r_state  <= ISSUE;
            r_mem_en <= 1'b1;
            if (w_ld_gnt) begin
`ifdef MEM_ARB_LOADER_EN
              r_owner     <= LD;
              r_store     <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_be    <= '1;
              r_mem_addr  <= bus.ld_addr;
              r_mem_wdata <= bus.ld_wdata;
`endif
            end else if (w_if_gnt) begin
              // Fetch leaves the write-data bus at its previous value.
              r_owner    <= IF;
              r_store    <= 1'b0;
              r_mem_we   <= 1'b0;
              r_mem_be   <= '1;
              r_mem_addr <= bus.if_addr;
            end else begin
              r_owner     <= LS;
              r_store     <= bus.ls_we;
              r_mem_we    <= bus.ls_we;
              r_mem_be    <= bus.ls_be;
              r_mem_addr  <= bus.ls_addr;
              r_mem_wdata <= bus.ls_wdata;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_owner == LD) begin
            r_state <= IDLE;
          end else begin
            r_state <= WAIT;
            r_cnt   <= c_one;
          end
        end
        WAIT: begin
          // r_cnt == k in cycle ISSUE+k; read data is valid when k == MEM_LAT.
          if (r_cnt == c_lat) begin
            r_state <= RESP;
            r_cnt   <= '0;
            if (r_owner == IF) begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= bus.mem_rdata;
            end else begin
              r_ls_rvalid <= 1'b1;
              r_ls_rdata  <= r_store ? '0 : bus.mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt + c_one;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.ls_gnt    = w_ls_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_rvalid = r_ls_rvalid;
  assign bus.ls_rdata  = r_ls_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.arb_busy  = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed checks of mem_port_arbiter at MEM_LAT=1 and MEM_LAT=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_ld  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b4 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  function automatic logic [31:0] init_word(input logic [7:0] idx);
    return 32'hA500_0000 | {24'd0, idx};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  // One-cycle RAM behind dut1; a poison word marks cycles without a read.
  logic [31:0] mem1 [256];
  initial begin
    for (int i = 0; i < 256; i++) mem1[i] = init_word(8'(i));
    mem1[8'h40] = 32'h0000_0013;
  end

  always @(posedge clk) begin
    if (b1.mem_en && b1.mem_we)
      mem1[b1.mem_addr[9:2]] <= merge(mem1[b1.mem_addr[9:2]], b1.mem_wdata, b1.mem_be);
    b1.mem_rdata <= (b1.mem_en && !b1.mem_we) ? mem1[b1.mem_addr[9:2]] : 32'hBAD0_0000;
  end

  // Four-stage read pipe behind dut4.
  logic [31:0] p4 [4];
  always @(posedge clk) begin
    p4[0] <= b4.mem_en ? init_word(b4.mem_addr[9:2]) : 32'hBAD0_0000;
    p4[1] <= p4[0];
    p4[2] <= p4[1];
    p4[3] <= p4[2];
  end
  assign b4.mem_rdata = p4[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    b1.if_req = 0; b1.if_addr = '0; b1.ls_req = 0; b1.ls_we = 0; b1.ls_be = 4'hF;
    b1.ls_addr = '0; b1.ls_wdata = '0;
    b4.if_req = 0; b4.if_addr = '0; b4.ls_req = 0; b4.ls_we = 0; b4.ls_be = 4'hF;
    b4.ls_addr = '0; b4.ls_wdata = '0;
`ifdef MEM_ARB_LOADER_EN
    b1.ld_req = 0; b1.ld_addr = '0; b1.ld_wdata = '0;
    b4.ld_req = 0; b4.ld_addr = '0; b4.ld_wdata = '0;
`endif
    rst_n = 0;

    // Reset state
    nxt(); #1;
    chk("rst_mem_en", b1.mem_en, 0);
    chk("rst_busy", b1.arb_busy, 0);
    chk("rst_if_rvalid", b1.if_rvalid, 0);
    chk("rst_if_rdata", b1.if_rdata, 0);
    chk("rst_mem_addr", b4.mem_addr, 0);
    nxt(); rst_n = 1;

    // Tie at reset: IF, then LS, then IF again
    nxt(); b1.if_req = 1; b1.if_addr = 32'h104; b1.ls_req = 1; b1.ls_we = 0; b1.ls_addr = 32'h108; #1;
    chk("tie0_if_gnt", b1.if_gnt, 1);
    chk("tie0_ls_gnt", b1.ls_gnt, 0);
    nxt(); b1.if_addr = 32'h10C; #1;
    chk("tie1_mem_en", b1.mem_en, 1);
    chk("tie1_mem_addr", b1.mem_addr, 32'h104);
    chk("tie1_ls_gnt", b1.ls_gnt, 0);
    nxt(); #1;
    chk("tie2_ls_gnt", b1.ls_gnt, 0);
    chk("tie2_busy", b1.arb_busy, 1);
    nxt(); #1;
    chk("tie3_if_rvalid", b1.if_rvalid, 1);
    chk("tie3_if_rdata", b1.if_rdata, 32'hA500_0041);
    chk("tie3_ls_gnt", b1.ls_gnt, 1);
    chk("tie3_if_gnt", b1.if_gnt, 0);
    nxt(); b1.ls_req = 0; #1;
    chk("tie4_mem_addr", b1.mem_addr, 32'h108);
    chk("tie4_if_rvalid", b1.if_rvalid, 0);
    nxt(); #1;
    chk("tie5_if_gnt", b1.if_gnt, 0);
    nxt(); #1;
    chk("tie6_ls_rvalid", b1.ls_rvalid, 1);
    chk("tie6_ls_rdata", b1.ls_rdata, 32'hA500_0042);
    chk("tie6_if_gnt", b1.if_gnt, 1);
    nxt(); b1.if_req = 0; #1;
    chk("tie7_mem_addr", b1.mem_addr, 32'h10C);
    nxt(); nxt(); #1;
    chk("tie9_if_rdata", b1.if_rdata, 32'hA500_0043);
    chk("tie9_ls_rdata_hold", b1.ls_rdata, 32'hA500_0042);
    chk("tie9_ls_rvalid", b1.ls_rvalid, 0);
    nxt(); #1;
    chk("tie10_busy", b1.arb_busy, 0);

    // Single fetch
    nxt(); b1.if_req = 1; b1.if_addr = 32'h100; #1;
    chk("f0_if_gnt", b1.if_gnt, 1);
    nxt(); b1.if_req = 0; #1;
    chk("f1_mem_en", b1.mem_en, 1);
    chk("f1_mem_addr", b1.mem_addr, 32'h100);
    chk("f1_mem_we", b1.mem_we, 0);
    chk("f1_mem_be", b1.mem_be, 4'hF);
    nxt(); #1;
    chk("f2_mem_en", b1.mem_en, 0);
    chk("f2_if_rvalid", b1.if_rvalid, 0);
    nxt(); #1;
    chk("f3_if_rvalid", b1.if_rvalid, 1);
    chk("f3_if_rdata", b1.if_rdata, 32'h0000_0013);
    nxt(); #1;
    chk("f4_if_rvalid", b1.if_rvalid, 0);
    chk("f4_busy", b1.arb_busy, 0);

    // Partial store, then read it back
    nxt(); b1.ls_req = 1; b1.ls_we = 1; b1.ls_be = 4'b0011; b1.ls_addr = 32'h200;
    b1.ls_wdata = 32'hDEAD_BEEF; #1;
    chk("st0_ls_gnt", b1.ls_gnt, 1);
    nxt(); b1.ls_req = 0; b1.ls_we = 0; b1.ls_be = 4'hF; #1;
    chk("st1_mem_en", b1.mem_en, 1);
    chk("st1_mem_we", b1.mem_we, 1);
    chk("st1_mem_be", b1.mem_be, 4'b0011);
    chk("st1_mem_wdata", b1.mem_wdata, 32'hDEAD_BEEF);
    nxt(); #1;
    chk("st2_mem_we", b1.mem_we, 0);
    chk("st2_mem_addr_hold", b1.mem_addr, 32'h200);
    nxt(); #1;
    chk("st3_ls_rvalid", b1.ls_rvalid, 1);
    chk("st3_ls_rdata", b1.ls_rdata, 0);
    nxt(); b1.ls_req = 1; #1;
    chk("ld0_ls_gnt", b1.ls_gnt, 1);
    nxt(); b1.ls_req = 0;
    nxt(); nxt(); #1;
    chk("ld3_ls_rdata", b1.ls_rdata, 32'hA500_BEEF);

    // Reset during WAIT abandons the fetch
    nxt(); b1.if_req = 1; b1.if_addr = 32'h100; #1;
    chk("rw0_if_gnt", b1.if_gnt, 1);
    nxt(); b1.if_req = 0;
    nxt(); rst_n = 0; #1;
    chk("rw_busy", b1.arb_busy, 0);
    chk("rw_mem_en", b1.mem_en, 0);
    chk("rw_if_rdata", b1.if_rdata, 0);
    chk("rw_mem_addr", b1.mem_addr, 0);
    nxt(); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("rw_no_rvalid", b1.if_rvalid, 0);
    end
    nxt(); b1.if_req = 1; b1.ls_req = 1; b1.ls_addr = 32'h108; #1;
    chk("rw_tie_if_gnt", b1.if_gnt, 1);
    chk("rw_tie_ls_gnt", b1.ls_gnt, 0);
    nxt(); b1.if_req = 0; b1.ls_req = 0;
    nxt(); nxt(); #1;
    chk("rw_fetch_rvalid", b1.if_rvalid, 1);
    chk("rw_fetch_rdata", b1.if_rdata, 32'h0000_0013);

    // MEM_LAT=4: response 6 cycles after acceptance, no grant meanwhile
    nxt(); b4.if_req = 1; b4.if_addr = 32'h104; b4.ls_req = 1; b4.ls_we = 0; b4.ls_addr = 32'h108; #1;
    chk("l0_if_gnt", b4.if_gnt, 1);
    nxt(); b4.if_req = 0; #1;
    chk("l1_mem_en", b4.mem_en, 1);
    chk("l1_ls_gnt", b4.ls_gnt, 0);
    for (int k = 2; k < 6; k++) begin
      nxt(); #1;
      chk("lw_ls_gnt", b4.ls_gnt, 0);
      chk("lw_if_rvalid", b4.if_rvalid, 0);
    end
    nxt(); #1;
    chk("l6_if_rvalid", b4.if_rvalid, 1);
    chk("l6_if_rdata", b4.if_rdata, 32'hA500_0041);
    chk("l6_ls_gnt", b4.ls_gnt, 1);
    nxt(); b4.ls_req = 0;
    nxt(); nxt(); nxt(); nxt(); #1;
    chk("l11_ls_rvalid", b4.ls_rvalid, 0);
    nxt(); #1;
    chk("l12_ls_rvalid", b4.ls_rvalid, 1);
    chk("l12_ls_rdata", b4.ls_rdata, 32'hA500_0042);

`ifdef MEM_ARB_LOADER_EN
    // Loader preload starves a waiting fetch
    nxt(); b1.if_req = 1; b1.if_addr = 32'h100;
    b1.ld_req = 1; b1.ld_addr = 32'h0; b1.ld_wdata = 32'h1000;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (b1.ld_gnt === 1'b1) n_ld++;
      chk("ldr_ld_gnt", b1.ld_gnt, 1);
      chk("ldr_if_gnt", b1.if_gnt, 0);
      nxt();
      b1.ld_addr = 32'(4 * (i + 1));
      b1.ld_wdata = 32'h1000 + 32'(i + 1);
      if (i == 15) b1.ld_req = 0;
      #1;
      chk("ldr_mem_we", b1.mem_we, 1);
      chk("ldr_mem_addr", b1.mem_addr, 32'(4 * i));
      chk("ldr_mem_wdata", b1.mem_wdata, 32'h1000 + 32'(i));
      chk("ldr_issue_gnt", b1.ld_gnt | b1.if_gnt, 0);
      nxt();
    end
    #1;
    chk("ldr_pulses", n_ld, 16);
    chk("ldr_if_gnt_after", b1.if_gnt, 1);
    nxt(); b1.if_req = 0;
    nxt(); nxt(); nxt();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified instruction/data memory behind the NF5 core between the instruction-fetch port and the load/store port. Round-robin arbitration between the two, one outstanding transaction at a time, and a fixed-latency memory protocol toward the RAM. An optional loader port lets the bench or boot logic preload program images through RTL instead of hierarchical writes.

## Interface
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: data width; byte-enable width is `DATA_W/8`.
- `MEM_LAT`, 1: cycles from the `mem_en` cycle to valid `mem_rdata`. Legal range 1..8.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; read only.
- `if_addr` in ADDR_W: fetch address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` valid.
- `if_rdata` out DATA_W: fetched word.
- `ls_req` in 1: load/store request.
- `ls_we` in 1: 1 = store.
- `ls_be` in DATA_W/8: byte enables for stores.
- `ls_addr` in ADDR_W: load/store address.
- `ls_wdata` in DATA_W: store data.
- `ls_gnt` out 1: load/store request accepted this cycle.
- `ls_rvalid` out 1: one-cycle pulse; load data, or store acknowledge.
- `ls_rdata` out DATA_W: load data; 0 for stores.
- `mem_en`, `mem_we` out 1: memory strobe and write enable.
- `mem_be` out DATA_W/8: memory byte enables.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data.
- `arb_busy` out 1: high whenever the state is not IDLE.
- Present only with `MEM_ARB_LOADER_EN`:
  - `ld_req` in 1: loader write request.
  - `ld_addr` in ADDR_W: loader address.
  - `ld_wdata` in DATA_W: loader data; full-word write.
  - `ld_gnt` out 1: loader request accepted.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **Grant rules**
  - A grant can occur only in IDLE or RESP.
  - At most one `*_gnt` is high per cycle.
  - Grants are combinational from the `*_req` inputs and the state.
  - Acceptance happens at the clock edge where req and gnt are both high.
- **Arbitration order**
  - Loader, when compiled in, always wins.
  - Otherwise, if both IF and LS request, grant the port that was not granted last.
  - The last-grant pointer resets to LS, so IF wins the first tie.
  - A lone requester is always granted.
- **On acceptance**
  - Register the owner and the request fields.
  - Go to ISSUE.
- **ISSUE** (exactly one cycle)
  - `mem_en` = 1, driving the registered address, data, we and be.
  - IF reads drive be = all ones, we = 0.
  - Loader requests drive we = 1, be = all ones.
  - Loader transactions return to IDLE after ISSUE; they get no response pulse.
  - All other transactions go to WAIT.
- **WAIT**
  - Counter width is `$clog2(MEM_LAT+1)`.
  - Capture `mem_rdata` on the edge that ends cycle ISSUE+`MEM_LAT`, then go to RESP.
- **RESP** (one cycle)
  - Owner's rvalid = 1, and its rdata = captured word (0 for stores).
  - The next request may be granted in the same cycle.
  - Next state is ISSUE if a grant occurred, else IDLE.
- The non-owner's rdata holds its last value; rvalid is a pulse only.
- Requesters hold req and its fields stable until gnt. Deasserting req before gnt is legal and issues nothing.

## Timing
- Acceptance at the edge ending cycle T:
  - `mem_en` is high in cycle T+1.
  - rvalid is high in cycle T+2+`MEM_LAT`.
- Back-to-back throughput is one IF/LS transaction per `MEM_LAT`+2 cycles.
- Loader throughput is one write per 2 cycles.
- Outside ISSUE, `mem_en` = 0 and `mem_we` = 0. Address and data then hold their last values.
- Reset values:
  - All outputs are 0.
  - State is IDLE, pointer is LS, counter is 0.
- Reset asserted mid-transaction abandons it. No rvalid is ever issued for it.

## Configuration
- `MEM_ARB_LOADER_EN` defined:
  - The loader ports exist, with absolute priority.
  - IF/LS starve while `ld_req` is held high; this is intended during preload.
- `MEM_ARB_LOADER_EN` undefined:
  - The loader ports and loader logic are absent.
  - Behaviour is otherwise identical.

## Structure
- Package `nf5_mem_pkg`:
  - `arb_state_t` enum (IDLE/ISSUE/WAIT/RESP).
  - `arb_owner_t` enum (IF/LS/LD).
  - Default width constants.
- Sub-module `rr_pick2`: two-input round-robin picker with the last-grant pointer. The arbiter instantiates it once.

## Test plan
- **Single fetch:** `MEM_LAT`=1, `if_req` with addr 0x100, mem returns 0x00000013 → `if_gnt` in cycle 0, `mem_en` in cycle 1, `if_rvalid` with 0x00000013 in cycle 3.
- **Tie:** IF and LS request together at reset → IF granted first, LS granted in IF's RESP cycle, then IF again if it still requests (alternation).
- **Store:** LS we=1, be=4'b0011, addr 0x200, wdata 0xDEADBEEF → `mem_we`=1, `mem_be`=0011 in the ISSUE cycle; `ls_rvalid` with `ls_rdata`=0.
- **Latency sweep:** `MEM_LAT`=4 → rvalid exactly 6 cycles after acceptance; no grant while in WAIT.
- **Reset mid-WAIT:** `rst_n` low during WAIT → all outputs 0 immediately, no rvalid afterwards, next tie grants IF.
- **Loader** (macro on): 16 writes of 0x1000+i to addresses 4i while `if_req` is high → 16 `ld_gnt` pulses at 2-cycle spacing, no `if_gnt` until `ld_req` drops.
